// File: rtl/intersection_traffic_model.sv
// Five-lane intersection traffic model: per-lane car queues driven by the
// controller's light colours, sensors back to the controller, and sticky
// checks for queue overflow, conflicting non-red lanes and illegal colour
// sequences.
// Optional feature macro: TRAFFIC_YELLOW_GO_EN (cars also depart on yellow).
// Light encoding: 2'b00 red, 2'b01 yellow, 2'b10 green; 2'b11 is treated as red.
// Lane order in every vector: [0]=ES, [1]=WS, [2]=EL, [3]=WL, [4]=NS.

module intersection_lane #(
    parameter int QMAX = 15,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    light,
    input  logic          arrive,
    output logic [CW-1:0] q,
    output logic          depart,
    output logic          ovf_ev,
    output logic          seq_ev
);
    localparam logic [1:0]    C_YEL  = 2'b01;
    localparam logic [1:0]    C_GRN  = 2'b10;
    localparam logic [CW-1:0] Q_FULL = CW'(QMAX);

    typedef enum logic [1:0] {PH_RED, PH_GRN, PH_YEL1, PH_YELN} phase_t;

    phase_t        ph, ph_nxt;
    logic [CW-1:0] q_nxt;
    logic          is_grn, is_yel, go;

    assign is_grn = (light == C_GRN);
    assign is_yel = (light == C_YEL);
`ifdef TRAFFIC_YELLOW_GO_EN
    assign go = is_grn | is_yel;
`else
    assign go = is_grn;
`endif
    assign depart = go && (q != '0);

    // Queue next value; an arrival and a departure in the same cycle cancel.
    always_comb begin
        q_nxt  = q;
        ovf_ev = 1'b0;
        if (arrive && !depart) begin
            if (q == Q_FULL) ovf_ev = 1'b1;
            else             q_nxt  = q + CW'(1);
        end else if (!arrive && depart) begin
            q_nxt = q - CW'(1);
        end
    end

    // Phase checker: track the colour sequence and flag illegal transitions.
    always_comb begin
        ph_nxt = ph;
        seq_ev = 1'b0;
        case (ph)
            PH_RED: begin
                if (is_grn) ph_nxt = PH_GRN;
                else if (is_yel) begin seq_ev = 1'b1; ph_nxt = PH_YEL1; end
            end
            PH_GRN: begin
                if (is_yel) ph_nxt = PH_YEL1;
                else if (!is_grn) begin seq_ev = 1'b1; ph_nxt = PH_RED; end
            end
            PH_YEL1: begin
                // Yellow must last at least two cycles.
                if (is_yel) ph_nxt = PH_YELN;
                else begin
                    seq_ev = 1'b1;
                    ph_nxt = is_grn ? PH_GRN : PH_RED;
                end
            end
            PH_YELN: begin
                if (is_grn) begin seq_ev = 1'b1; ph_nxt = PH_GRN; end
                else if (!is_yel) ph_nxt = PH_RED;
            end
            default: ph_nxt = PH_RED;
        endcase
    end

    // Queue and phase registers; frozen until the synchronized reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q  <= '0;
            ph <= PH_RED;
        end else if (en) begin
            q  <= q_nxt;
            ph <= ph_nxt;
        end
    end
endmodule

module intersection_traffic_model #(
    parameter int QMAX = 15,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    e_str_light,
    input  logic [1:0]    w_str_light,
    input  logic [1:0]    e_left_light,
    input  logic [1:0]    w_left_light,
    input  logic [1:0]    ns_light,
    input  logic [4:0]    arrive,
    output logic          e_str_sensor,
    output logic          w_str_sensor,
    output logic          e_left_sensor,
    output logic          w_left_sensor,
    output logic          ns_sensor,
    output logic [4:0]    depart,
    output logic [CW-1:0] q_es,
    output logic [CW-1:0] q_ws,
    output logic [CW-1:0] q_el,
    output logic [CW-1:0] q_wl,
    output logic [CW-1:0] q_ns,
    output logic          overflow_err,
    output logic          conflict_err,
    output logic          seq_err
);
    localparam int NUM_LANES = 5;

    if (QMAX < 1 || QMAX > 255 || QMAX > (2**CW) - 1) begin : g_bad_cfg
        $error("intersection_traffic_model: QMAX must be 1..255 and fit in CW bits");
    end

    logic                          run;
    logic [NUM_LANES-1:0][1:0]     light;
    logic [NUM_LANES-1:0][CW-1:0]  q;
    logic [NUM_LANES-1:0]          nonred, ovf_ev, seq_ev;
    logic                          conflict;

    assign light = {ns_light, w_left_light, e_left_light, w_str_light, e_str_light};

    // Release synchronizer: the edge that sees reset high only arms 'run',
    // so the first state update lands on the second rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run <= 1'b0;
        else        run <= 1'b1;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        intersection_lane #(.QMAX(QMAX), .CW(CW)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en     (run),
            .light  (light[i]),
            .arrive (arrive[i]),
            .q      (q[i]),
            .depart (depart[i]),
            .ovf_ev (ovf_ev[i]),
            .seq_ev (seq_ev[i])
        );
        assign nonred[i] = (light[i] == 2'b01) || (light[i] == 2'b10);
    end

    // Only ES/WS, ES/EL, WS/WL and EL/WL may be non-red together; NS shares with nobody.
    assign conflict = (nonred[4] && (|nonred[3:0]))
                   || (nonred[0] && nonred[3])
                   || (nonred[1] && nonred[2]);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_err <= 1'b0;
            conflict_err <= 1'b0;
            seq_err      <= 1'b0;
        end else if (run) begin
            overflow_err <= overflow_err | (|ovf_ev);
            conflict_err <= conflict_err | conflict;
            seq_err      <= seq_err      | (|seq_ev);
        end
    end

    assign q_es = q[0];
    assign q_ws = q[1];
    assign q_el = q[2];
    assign q_wl = q[3];
    assign q_ns = q[4];

    assign e_str_sensor  = (q[0] != '0);
    assign w_str_sensor  = (q[1] != '0);
    assign e_left_sensor = (q[2] != '0);
    assign w_left_sensor = (q[3] != '0);
    assign ns_sensor     = (q[4] != '0);
endmodule
